// File: rtl/bullet_pkg.sv
// Shared constants for the bullet sequencer: FSM state codes, screen size and colours.
package bullet_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAW   = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] ERASE  = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BULLET = 3'b110;
  localparam logic [2:0] COLOUR_BG     = 3'b000;

endpackage

// File: rtl/bullet_control_scanner.sv
// Walks the BW x BH sprite footprint, dx fast and dy slow, while start is held high.
module sprite_scanner #(
  parameter int BW = 2,
  parameter int BH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  localparam logic [1:0] DX_LAST = 2'(BW - 1);
  localparam logic [2:0] DY_LAST = 3'(BH - 1);

  assign last = (dx == DX_LAST) && (dy == DY_LAST);

  // Counters sit at (0,0) whenever no scan is active, so every scan starts at the origin.
  always_ff @(posedge clk) begin
    if (reset || !start) begin
      dx <= '0;
      dy <= '0;
    end else if (dx == DX_LAST) begin
      dx <= '0;
      dy <= (dy == DY_LAST) ? 3'd0 : dy + 3'd1;
    end else begin
      dx <= dx + 2'd1;
    end
  end

endmodule

// File: rtl/bullet_control.sv
// Bullet sequencer: drives the position handler strobes and draws/erases the sprite each frame step.
module bullet_control
  import bullet_pkg::*;
#(
  parameter int          FRAME_CYCLES  = 833333,
  parameter int          BW            = 2,
  parameter int          BH            = 4,
  parameter logic [2:0]  BULLET_COLOUR = COLOUR_BULLET,
  parameter logic [2:0]  BG_COLOUR     = COLOUR_BG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic [7:0] bulletX,
  input  logic [6:0] bulletY,
  input  logic       reachtop,
  output logic       outResetb,
  output logic       outUpdateb,
  output logic       outWaitb,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam int             FW         = $clog2(FRAME_CYCLES) + 1;
  localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAME_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [FW-1:0] frame_cnt;
  logic          scanning;
  logic [1:0]    dx;
  logic [2:0]    dy;
  logic          scan_last;
  logic [8:0]    sum_x;
  logic [7:0]    sum_y;
  logic          on_screen;

  assign scanning = (state == DRAW) || (state == ERASE);

  sprite_scanner #(.BW(BW), .BH(BH)) scanner (
    .clk   (clk),
    .reset (reset),
    .start (scanning),
    .dx    (dx),
    .dy    (dy),
    .last  (scan_last)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fire) next_state = DRAW;
      DRAW:    if (scan_last) next_state = WAIT;
      WAIT:    if (frame_cnt == FRAME_LAST) next_state = ERASE;
      ERASE:   if (scan_last) next_state = UPDATE;
      UPDATE:  next_state = CHECK;
      CHECK:   next_state = reachtop ? IDLE : DRAW;
      default: next_state = IDLE;
    endcase
  end

  // The frame counter only runs inside WAIT, so it is already zero on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= next_state;
      frame_cnt <= (state == WAIT) ? frame_cnt + 1'b1 : '0;
    end
  end

  // Sums are one bit wider than the screen coordinates so off-screen pixels can be suppressed.
  assign sum_x     = {1'b0, bulletX} + {7'b0, dx};
  assign sum_y     = {1'b0, bulletY} + {5'b0, dy};
  assign on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

  assign vga_x      = scanning ? sum_x[7:0] : 8'd0;
  assign vga_y      = scanning ? sum_y[6:0] : 7'd0;
  assign vga_plot   = scanning && on_screen;
  assign vga_colour = (state == DRAW) ? BULLET_COLOUR : BG_COLOUR;
  assign outResetb  = (state == IDLE);
  assign outUpdateb = (state == UPDATE);
  assign outWaitb   = (state == WAIT);
  assign busy       = (state != IDLE);

endmodule
